// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and sizes for the PUF DUS conditioner
package puf_pkg;

    localparam int DUS_W     = 256;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACCUM,
        EVAL,
        CHECK,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNSTABLE = 2'd1,
        ERR_STUCK    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    function automatic logic [5:0] popcount32(input logic [WORD_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/puf_dus_conditioner_if.sv
// rtl/puf_dus_conditioner_if.sv - word read handshake between conditioner and PUF array
interface puf_dus_conditioner_if;
    import puf_pkg::*;

    logic              puf_req;
    logic [2:0]        puf_addr;
    logic              puf_ack;
    logic [WORD_W-1:0] puf_data;

    modport master (
        output puf_req,
        output puf_addr,
        input  puf_ack,
        input  puf_data
    );

    modport slave (
        input  puf_req,
        input  puf_addr,
        output puf_ack,
        output puf_data
    );

endinterface

// File: rtl/puf_vote_bank.sv
// rtl/puf_vote_bank.sv - per-bit vote counters for one 32-bit PUF word
module puf_vote_bank
    import puf_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic [WORD_W-1:0]       data,
    output logic [WORD_W*CNT_W-1:0] counts
);

    // NUM_READS never exceeds 15, so the counters cannot wrap
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            counts <= '0;
        end else if (en) begin
            for (int i = 0; i < WORD_W; i++) begin
                counts[i*CNT_W +: CNT_W] <= counts[i*CNT_W +: CNT_W]
                                          + {{(CNT_W-1){1'b0}}, data[i]};
            end
        end
    end

endmodule

// File: rtl/puf_dus_conditioner.sv
// rtl/puf_dus_conditioner.sv - repeated PUF readout, per-bit majority vote and health check
module puf_dus_conditioner
    import puf_pkg::*;
#(
    parameter int NUM_READS    = 5,
    parameter int MAX_UNSTABLE = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 generate_pulse,
    output logic                 busy,
    puf_dus_conditioner_if.master puf,
    output logic [DUS_W-1:0]     dus_secret,
    output logic                 dus_valid,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [8:0]           unstable_count
);

    localparam logic [CNT_W-1:0] HALF_READS = CNT_W'(NUM_READS / 2);
    localparam logic [CNT_W-1:0] ALL_READS  = CNT_W'(NUM_READS);
    localparam logic [3:0]       LAST_READ  = 4'(NUM_READS - 1);
    localparam logic [7:0]       TMO_LIMIT  = 8'(TIMEOUT);
    localparam logic [8:0]       MAX_UNST   = 9'(MAX_UNSTABLE);

    state_t              state;
    err_code_t           err_q;
    logic [2:0]          word;
    logic [3:0]          read_idx;
    logic [7:0]          tmo_cnt;
    logic [WORD_W-1:0]   cap;
    logic [DUS_W-1:0]    result;
    logic                req_q;
    logic [2:0]          addr_q;
    logic                start_ok;

    logic [WORD_W*CNT_W-1:0] bank_counts [NUM_WORDS];
    logic [WORD_W*CNT_W-1:0] eval_counts;
    logic [WORD_W-1:0]       eval_maj;
    logic [WORD_W-1:0]       eval_unst;

    assign puf.puf_req  = req_q;
    assign puf.puf_addr = addr_q;
    assign error_code   = err_q;

    assign start_ok = generate_pulse
                   && (state == IDLE || state == DONE || state == ERROR);

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_bank
        puf_vote_bank u_bank (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (start_ok),
            .en      (state == ACCUM && word == 3'(k)),
            .data    (cap),
            .counts  (bank_counts[k])
        );
    end

    // Majority and instability of the word currently being evaluated
    always_comb begin
        eval_counts = bank_counts[word];
        eval_maj    = '0;
        eval_unst   = '0;
        for (int i = 0; i < WORD_W; i++) begin
            eval_maj[i]  = eval_counts[i*CNT_W +: CNT_W] > HALF_READS;
            eval_unst[i] = (eval_counts[i*CNT_W +: CNT_W] != '0)
                        && (eval_counts[i*CNT_W +: CNT_W] != ALL_READS);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            err_q          <= ERR_NONE;
            word           <= '0;
            read_idx       <= '0;
            tmo_cnt        <= '0;
            cap            <= '0;
            result         <= '0;
            req_q          <= 1'b0;
            addr_q         <= '0;
            busy           <= 1'b0;
            dus_secret     <= '0;
            dus_valid      <= 1'b0;
            error          <= 1'b0;
            unstable_count <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (generate_pulse) begin
                        state          <= REQ;
                        err_q          <= ERR_NONE;
                        word           <= '0;
                        read_idx       <= '0;
                        tmo_cnt        <= '0;
                        result         <= '0;
                        req_q          <= 1'b1;
                        addr_q         <= '0;
                        busy           <= 1'b1;
                        dus_secret     <= '0;
                        dus_valid      <= 1'b0;
                        error          <= 1'b0;
                        unstable_count <= '0;
                    end
                end
                REQ: begin
                    if (puf.puf_ack) begin
                        cap   <= puf.puf_data;
                        req_q <= 1'b0;
                        state <= ACCUM;
                    end else if (tmo_cnt + 8'd1 == TMO_LIMIT) begin
                        req_q <= 1'b0;
                        busy  <= 1'b0;
                        error <= 1'b1;
                        err_q <= ERR_TIMEOUT;
                        state <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ACCUM: begin
                    tmo_cnt <= '0;
                    if (word != 3'd7) begin
                        word   <= word + 3'd1;
                        addr_q <= word + 3'd1;
                        req_q  <= 1'b1;
                        state  <= REQ;
                    end else if (read_idx != LAST_READ) begin
                        word     <= '0;
                        addr_q   <= '0;
                        read_idx <= read_idx + 4'd1;
                        req_q    <= 1'b1;
                        state    <= REQ;
                    end else begin
                        word  <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    result[{word, 5'd0} +: WORD_W] <= eval_maj;
                    unstable_count <= unstable_count + {3'b000, popcount32(eval_unst)};
                    if (word == 3'd7) begin
                        word  <= '0;
                        state <= CHECK;
                    end else begin
                        word <= word + 3'd1;
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    if (unstable_count > MAX_UNST) begin
                        error <= 1'b1;
                        err_q <= ERR_UNSTABLE;
                        state <= ERROR;
                    end else if (result == '0 || result == '1) begin
                        error <= 1'b1;
                        err_q <= ERR_STUCK;
                        state <= ERROR;
                    end else begin
                        dus_secret <= result;
                        dus_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_dus_conditioner.sv
// tb/tb_puf_dus_conditioner.sv - directed scoreboard bench for puf_dus_conditioner
module tb_puf_dus_conditioner;

    logic         clock;
    logic         reset_n;
    logic         generate_pulse;
    logic         busy;
    logic [255:0] dus_secret;
    logic         dus_valid;
    logic         error;
    logic [1:0]   error_code;
    logic [8:0]   unstable_count;

    puf_dus_conditioner_if pif ();

    puf_dus_conditioner dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .generate_pulse (generate_pulse),
        .busy           (busy),
        .puf            (pif),
        .dus_secret     (dus_secret),
        .dus_valid      (dus_valid),
        .error          (error),
        .error_code     (error_code),
        .unstable_count (unstable_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         valid;
        logic         err;
        logic [1:0]   code;
        logic [8:0]   unst;
        logic [255:0] secret;
        int           edges;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   mode = 0;
    logic ack_en = 1'b1;
    logic stray_ack = 1'b0;
    int   ack_count = 0;
    int   ack_base = 0;

    // Mode 0 constant, 1 single bit flipped in reads 1 and 3, 2 forty bits flipped in read 2, 3 all zero
    function automatic logic [31:0] puf_word(input int m, input int rd, input logic [2:0] a);
        logic [31:0] w;
        w = 32'hA5A5_0000 | {29'd0, a};
        if (m == 3) w = 32'd0;
        if (m == 1 && a == 3'd3 && (rd == 1 || rd == 3)) w[0] = ~w[0];
        if (m == 2 && rd == 2) begin
            if (a == 3'd0) w = ~w;
            else if (a == 3'd1) w[7:0] = ~w[7:0];
        end
        return w;
    endfunction

    function automatic logic [255:0] const_secret();
        logic [255:0] s;
        for (int k = 0; k < 8; k++) s[32*k +: 32] = 32'hA5A5_0000 | 32'(k);
        return s;
    endfunction

    assign pif.puf_ack  = (pif.puf_req && ack_en) || stray_ack;
    assign pif.puf_data = pif.puf_req ? puf_word(mode, (ack_count - ack_base) / 8, pif.puf_addr)
                                      : 32'hFFFF_FFFF;

    always @(posedge clock) begin
        if (pif.puf_req && pif.puf_ack) ack_count <= ack_count + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic v, input logic e, input logic [1:0] c,
                            input logic [8:0] u, input logic [255:0] s, input int n);
        exp_t x;
        x.valid = v; x.err = e; x.code = c; x.unst = u; x.secret = s; x.edges = n;
        sb.push_back(x);
    endtask

    task automatic pulse_gen();
        ack_base = ack_count;
        @(negedge clock);
        generate_pulse = 1'b1;
        @(posedge clock);
        #1;
        generate_pulse = 1'b0;
    endtask

    // Counts edges until busy drops; optionally re-pulses generate while busy
    task automatic run_and_check(input string tag, input int poke_at);
        int   edges;
        exp_t x;
        pulse_gen();
        edges = 0;
        while (busy && edges < 5000) begin
            generate_pulse = (edges == poke_at);
            @(posedge clock);
            #1;
            edges++;
        end
        generate_pulse = 1'b0;
        x = sb.pop_front();
        check({tag, " edges"},  256'(edges),          256'(x.edges));
        check({tag, " valid"},  256'(dus_valid),      256'(x.valid));
        check({tag, " error"},  256'(error),          256'(x.err));
        check({tag, " code"},   256'(error_code),     256'(x.code));
        check({tag, " unst"},   256'(unstable_count), 256'(x.unst));
        check({tag, " secret"}, dus_secret,           x.secret);
    endtask

    initial begin
        int guard;
        reset_n        = 1'b0;
        generate_pulse = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst busy",  256'(busy),           256'(0));
        check("rst req",   256'(pif.puf_req),    256'(0));
        check("rst valid", 256'(dus_valid),      256'(0));
        check("rst error", 256'(error),          256'(0));
        check("rst unst",  256'(unstable_count), 256'(0));
        check("rst secret", dus_secret,          256'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        mode = 0;
        push_exp(1'b1, 1'b0, 2'd0, 9'd0, const_secret(), 89);
        run_and_check("const", -1);

        mode = 1;
        push_exp(1'b1, 1'b0, 2'd0, 9'd1, const_secret(), 89);
        run_and_check("flip1", 88);

        mode = 2;
        push_exp(1'b0, 1'b1, 2'd1, 9'd40, 256'd0, 89);
        run_and_check("unstable", -1);

        mode = 3;
        push_exp(1'b0, 1'b1, 2'd2, 9'd0, 256'd0, 89);
        run_and_check("stuck", -1);

        mode = 0;
        push_exp(1'b1, 1'b0, 2'd0, 9'd0, const_secret(), 89);
        run_and_check("recover", -1);

        stray_ack = 1'b1;
        push_exp(1'b1, 1'b0, 2'd0, 9'd0, const_secret(), 89);
        run_and_check("stray", 40);
        stray_ack = 1'b0;

        ack_en = 1'b0;
        push_exp(1'b0, 1'b1, 2'd3, 9'd0, 256'd0, 255);
        run_and_check("timeout", -1);
        check("timeout req", 256'(pif.puf_req), 256'(0));
        ack_en = 1'b1;

        pulse_gen();
        guard = 0;
        while ((ack_count - ack_base) < 24 && guard < 5000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("reach read3", 256'(guard < 5000), 256'(1));
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("abort busy",  256'(busy),           256'(0));
        check("abort req",   256'(pif.puf_req),    256'(0));
        check("abort valid", 256'(dus_valid),      256'(0));
        check("abort error", 256'(error),          256'(0));
        check("abort code",  256'(error_code),     256'(0));
        check("abort unst",  256'(unstable_count), 256'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        mode = 1;
        push_exp(1'b1, 1'b0, 2'd0, 9'd1, const_secret(), 89);
        run_and_check("after rst", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
